bcd_split_seq: RTL and testbench

Parametrised, sequential binary-to-BCD converter: accepts an unsigned WIDTH-bit value on a start strobe and produces DIGITS packed BCD digits using iterative shift-and-add-3, one input bit per clock. It generalises the fixed two-digit tens/ones splitter used in the date and time display paths. It serves any counter width and digit count feeding the seven-segment drivers, and adds an explicit handshake and overflow detection.

---
 rtl/bcd_split_seq_pkg.sv | 12 +
 rtl/bcd_split_seq_adj3.sv | 14 +
 rtl/bcd_split_seq.sv | 92 +++++++++
 tb/tb_bcd_split_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_split_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_split_seq_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_split_seq_adj3.sv
// Per-digit shift-and-add-3 correction: values 5..15 get +3, modulo 16.
module bcd_adj3
  import bcd_split_seq_pkg::*;
(
  input  logic [BCD_W-1:0] val,
  output logic [BCD_W-1:0] adj
);

  always_comb begin
    adj = val;
    if (val >= BCD_W'(5)) adj = val + BCD_W'(3);
  end

endmodule

// File: rtl/bcd_split_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, with start/done handshake.
//   state   | meaning
//   IDLE    | waiting for start, outputs hold last result
//   CONV    | shifting one binary bit per cycle into the BCD register
//   DONE    | one-cycle result strobe, may accept a new start
module bcd_split_seq
  import bcd_split_seq_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    overflow
);

  localparam int BW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    bcd_w;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_shift;
  logic [CW-1:0]    cnt;
  logic             sticky;
  logic             sticky_nxt;
  logic             accept;
  logic             last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .val (bcd_w[g*BCD_W +: BCD_W]),
      .adj (adj[g*BCD_W +: BCD_W])
    );
  end

  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign last       = (state == ST_CONV) && (cnt == CW'(1));
  assign bcd_shift  = {adj[BW-2:0], bin_sr[WIDTH-1]};
  // A bit leaving the top digit means the value needs more than DIGITS digits.
  assign sticky_nxt = sticky | adj[BW-1];

  assign busy = (state == ST_CONV);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CONV;
      ST_CONV: if (cnt == CW'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_CONV : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd_w    <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      bin_sr <= bin_in;
      bcd_w  <= '0;
      cnt    <= CW'(WIDTH);
      sticky <= 1'b0;
    end else if (state == ST_CONV) begin
      bin_sr <= bin_sr << 1;
      bcd_w  <= bcd_shift;
      cnt    <= cnt - CW'(1);
      sticky <= sticky_nxt;
      if (last) begin
        bcd_out  <= sticky_nxt ? {DIGITS{4'h9}} : bcd_shift;
        overflow <= sticky_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_split_seq.sv
// Self-checking bench: four converter configurations against a decimal-split reference model.
module tb_bcd_split_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [4];
  logic [4:0]  bin0;
  logic [7:0]  bin1;
  logic [7:0]  bin2;
  logic [6:0]  bin3;
  logic        busy [4];
  logic        done [4];
  logic        ovf  [4];
  logic [7:0]  bcd0;
  logic [7:0]  bcd1;
  logic [11:0] bcd2;
  logic [11:0] bcd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_split_seq #(.WIDTH(5), .DIGITS(2)) u_w5d2 (
    .clk(clk), .rst(rst), .start(start[0]), .bin_in(bin0),
    .busy(busy[0]), .done(done[0]), .bcd_out(bcd0), .overflow(ovf[0]));
  bcd_split_seq #(.WIDTH(8), .DIGITS(2)) u_w8d2 (
    .clk(clk), .rst(rst), .start(start[1]), .bin_in(bin1),
    .busy(busy[1]), .done(done[1]), .bcd_out(bcd1), .overflow(ovf[1]));
  bcd_split_seq #(.WIDTH(8), .DIGITS(3)) u_w8d3 (
    .clk(clk), .rst(rst), .start(start[2]), .bin_in(bin2),
    .busy(busy[2]), .done(done[2]), .bcd_out(bcd2), .overflow(ovf[2]));
  bcd_split_seq #(.WIDTH(7), .DIGITS(3)) u_w7d3 (
    .clk(clk), .rst(rst), .start(start[3]), .bin_in(bin3),
    .busy(busy[3]), .done(done[3]), .bcd_out(bcd3), .overflow(ovf[3]));

  function automatic int w_of(input int k);
    case (k)
      0:       return 5;
      1, 2:    return 8;
      default: return 7;
    endcase
  endfunction

  function automatic int d_of(input int k);
    return (k < 2) ? 2 : 3;
  endfunction

  function automatic logic [11:0] bcd_of(input int k);
    case (k)
      0:       return {4'h0, bcd0};
      1:       return {4'h0, bcd1};
      2:       return bcd2;
      default: return bcd3;
    endcase
  endfunction

  // Reference: decimal split by repeated /10, saturating to all nines when too large.
  function automatic logic [12:0] ref_bcd(input int v, input int d);
    int lim = 1;
    logic [11:0] r = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd9;
      return {1'b1, r};
    end
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {1'b0, r};
  endfunction

  task automatic set_in(input int k, input logic s, input int v);
    start[k] = s;
    case (k)
      0:       bin0 = 5'(v);
      1:       bin1 = 8'(v);
      2:       bin2 = 8'(v);
      default: bin3 = 7'(v);
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: latency, result, overflow and single-cycle done pulse.
  task automatic do_conv(input int k, input int v, input string tag);
    logic [12:0] exp;
    int n;
    exp = ref_bcd(v, d_of(k));
    set_in(k, 1'b1, v);
    tick();
    set_in(k, 1'b0, 0);
    chk({tag, " busy_after_start"}, 32'(busy[k]), 32'd1);
    n = 0;
    while (!done[k] && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, w_of(k));
    chk({tag, " busy_at_done"}, 32'(busy[k]), 32'd0);
    chk({tag, " bcd"}, 32'(bcd_of(k)), 32'(exp[11:0]));
    chk({tag, " ovf"}, 32'(ovf[k]), 32'(exp[12]));
    tick();
    chk({tag, " done_width"}, 32'(done[k]), 32'd0);
  endtask

  initial begin
    int seen;
    for (int k = 0; k < 4; k++) set_in(k, 1'b0, 0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("reset busy", 32'(busy[k]), 32'd0);
      chk("reset done", 32'(done[k]), 32'd0);
      chk("reset bcd", 32'(bcd_of(k)), 32'd0);
      chk("reset ovf", 32'(ovf[k]), 32'd0);
    end
    tick();

    do_conv(0, 31, "w5 v31");
    do_conv(0, 0, "w5 v0");
    set_in(0, 1'b0, 19);
    repeat (4) tick();
    chk("hold between conversions", 32'(bcd0), 32'h00);
    do_conv(0, 19, "w5 v19");

    // Back-to-back with start held into DONE, plus a start pulse during CONV.
    set_in(0, 1'b1, 27);
    tick();
    bin0 = 5'd10;
    repeat (5) tick();
    chk("b2b done1", 32'(done[0]), 32'd1);
    chk("b2b bcd1", 32'(bcd0), 32'h27);
    tick();
    start[0] = 1'b0;
    chk("b2b reaccept busy", 32'(busy[0]), 32'd1);
    chk("b2b reaccept done", 32'(done[0]), 32'd0);
    tick();
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    chk("b2b not done early", 32'(done[0]), 32'd0);
    tick();
    chk("b2b done2", 32'(done[0]), 32'd1);
    chk("b2b bcd2", 32'(bcd0), 32'h10);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done[0] || busy[0]) seen++;
    end
    chk("no queued conversion", seen, 0);
    chk("b2b bcd held", 32'(bcd0), 32'h10);

    // Reset in the third CONV cycle aborts without a done pulse.
    set_in(0, 1'b1, 31);
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy[0]), 32'd0);
    chk("abort bcd", 32'(bcd0), 32'd0);
    chk("abort ovf", 32'(ovf[0]), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done[0]) seen++;
      tick();
    end
    chk("abort no done", seen, 0);
    do_conv(0, 17, "w5 v17");

    do_conv(1, 200, "w8d2 v200");
    do_conv(1, 99, "w8d2 v99");
    do_conv(1, 100, "w8d2 v100");
    do_conv(2, 255, "w8d3 v255");
    do_conv(2, 0, "w8d3 v0");

    for (int i = 0; i < 12; i++) begin
      do_conv(0, int'($urandom_range(0, 31)), "w5 rand");
      do_conv(1, int'($urandom_range(0, 255)), "w8d2 rand");
      do_conv(2, int'($urandom_range(0, 255)), "w8d3 rand");
    end

    for (int v = 0; v < 128; v++) do_conv(3, v, "w7d3 sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
